// File: rtl/fret_pkg.sv
// Shared types and constants for the fret row renderer.
package fret_pkg;

  typedef enum logic [1:0] {
    LS_IDLE    = 2'd0,
    LS_PRESSED = 2'd1,
    LS_HIT     = 2'd2,
    LS_MISS    = 2'd3
  } lane_state_t;

  localparam logic [1:0] OP_SET_PRESS = 2'b00;
  localparam logic [1:0] OP_HIT       = 2'b01;
  localparam logic [1:0] OP_MISS      = 2'b10;
  localparam logic [1:0] OP_CLEAR     = 2'b11;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t RGB_WHITE = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb12_t RGB_MISS  = '{r: 4'h8, g: 4'h0, b: 4'h0};

  // Lane colours: green, red, yellow, blue, orange, then three spares.
  function automatic rgb12_t palette(input int unsigned idx);
    case (idx)
      0:       palette = '{r: 4'h0, g: 4'hF, b: 4'h0};
      1:       palette = '{r: 4'hF, g: 4'h0, b: 4'h0};
      2:       palette = '{r: 4'hF, g: 4'hF, b: 4'h0};
      3:       palette = '{r: 4'h0, g: 4'h0, b: 4'hF};
      4:       palette = '{r: 4'hF, g: 4'h8, b: 4'h0};
      5:       palette = '{r: 4'h8, g: 4'h0, b: 4'h8};
      6:       palette = '{r: 4'h0, g: 4'hF, b: 4'hF};
      default: palette = '{r: 4'h8, g: 4'h8, b: 4'h8};
    endcase
  endfunction

  // Idle lanes are drawn at half intensity.
  function automatic rgb12_t dim(input rgb12_t c);
    dim = '{r: c.r >> 1, g: c.g >> 1, b: c.b >> 1};
  endfunction

endpackage

// File: rtl/fret_lane.sv
// One fret lane: press/hit/miss FSM, flash counter, box hit-test and colour.
module fret_lane
  import fret_pkg::*;
#(
  parameter int LANE_IDX     = 0,
  parameter int LANE_X0      = 160,
  parameter int LANE_PITCH   = 64,
  parameter int FRET_W       = 48,
  parameter int FRET_H       = 16,
  parameter int FRET_Y       = 400,
  parameter int FLASH_FRAMES = 8,
  parameter int MISS_FRAMES  = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [9:0] i_draw_x,
  input  logic [9:0] i_draw_y,
  input  logic       i_tick,
  input  logic       i_set_press,
  input  logic       i_press_val,
  input  logic       i_hit,
  input  logic       i_miss,
  input  logic       i_clear,
  output logic       o_in_box,
  output rgb12_t     o_rgb
);

  localparam int         X_LO_I = LANE_X0 + LANE_IDX * LANE_PITCH;
  localparam logic [10:0] X_LO  = 11'(X_LO_I);
  localparam logic [10:0] X_HI  = 11'(X_LO_I + FRET_W);
  localparam logic [10:0] Y_LO  = 11'(FRET_Y);
  localparam logic [10:0] Y_HI  = 11'(FRET_Y + FRET_H);

  lane_state_t r_state;
  logic [7:0]  r_ctr;
  logic        r_press;
  logic [10:0] w_x, w_y;
  rgb12_t      w_col;

  // Lane FSM: commands take priority over frame ageing; CLEAR over everything.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= LS_IDLE;
      r_ctr   <= '0;
      r_press <= 1'b0;
    end else if (i_clear) begin
      r_state <= LS_IDLE;
      r_ctr   <= '0;
      r_press <= 1'b0;
    end else begin
      if (i_set_press) r_press <= i_press_val;
      if (i_hit) begin
        r_state <= LS_HIT;
        r_ctr   <= 8'(FLASH_FRAMES);
      end else if (i_miss) begin
        r_state <= LS_MISS;
        r_ctr   <= 8'(MISS_FRAMES);
      end else begin
        case (r_state)
          LS_IDLE:    if (r_press)  r_state <= LS_PRESSED;
          LS_PRESSED: if (!r_press) r_state <= LS_IDLE;
          default: begin
            if (i_tick) begin
              if (r_ctr == 8'd1) begin
                r_state <= r_press ? LS_PRESSED : LS_IDLE;
                r_ctr   <= '0;
              end else begin
                r_ctr <= r_ctr - 8'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign w_x      = {1'b0, i_draw_x};
  assign w_y      = {1'b0, i_draw_y};
  assign o_in_box = (w_x >= X_LO) && (w_x < X_HI) && (w_y >= Y_LO) && (w_y < Y_HI);

  // Colour from current lane state; zero outside the box so the bank can OR lanes.
  always_comb begin
    w_col = dim(palette(LANE_IDX));
    case (r_state)
      LS_PRESSED: w_col = palette(LANE_IDX);
      LS_HIT:     w_col = RGB_WHITE;
      LS_MISS:    w_col = RGB_MISS;
      default:    w_col = dim(palette(LANE_IDX));
    endcase
    o_rgb = o_in_box ? w_col : '0;
  end

endmodule

// File: rtl/fret_bank.sv
// N-lane fret row: command decode, lane array, registered pixel output.
module fret_bank
  import fret_pkg::*;
#(
  parameter int N_LANES      = 5,
  parameter int LANE_X0      = 160,
  parameter int LANE_PITCH   = 64,
  parameter int FRET_W       = 48,
  parameter int FRET_H       = 16,
  parameter int FRET_Y       = 400,
  parameter int FLASH_FRAMES = 8,
  parameter int MISS_FRAMES  = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        frame_tick,
  input  logic        write,
  input  logic [31:0] data_in,
  output logic        active,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  logic [1:0]              w_op;
  logic [N_LANES-1:0]      w_mask;
  logic                    w_set, w_hit, w_miss, w_clear;
  logic [N_LANES-1:0]      w_in_box;
  rgb12_t [N_LANES-1:0]    w_rgb;
  logic                    w_any;
  logic [11:0]             w_mix;
  logic                    w_unused;

  assign w_op     = data_in[31:30];
  assign w_mask   = data_in[N_LANES-1:0];
  assign w_set    = write && (w_op == OP_SET_PRESS);
  assign w_hit    = write && (w_op == OP_HIT);
  assign w_miss   = write && (w_op == OP_MISS);
  assign w_clear  = write && (w_op == OP_CLEAR);
  assign w_unused = ^data_in[29:N_LANES];

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    fret_lane #(
      .LANE_IDX(g), .LANE_X0(LANE_X0), .LANE_PITCH(LANE_PITCH),
      .FRET_W(FRET_W), .FRET_H(FRET_H), .FRET_Y(FRET_Y),
      .FLASH_FRAMES(FLASH_FRAMES), .MISS_FRAMES(MISS_FRAMES)
    ) u_lane (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .i_draw_x    (DrawX),
      .i_draw_y    (DrawY),
      .i_tick      (frame_tick),
      .i_set_press (w_set),
      .i_press_val (w_mask[g]),
      .i_hit       (w_hit && w_mask[g]),
      .i_miss      (w_miss && w_mask[g]),
      .i_clear     (w_clear),
      .o_in_box    (w_in_box[g]),
      .o_rgb       (w_rgb[g])
    );
  end

  // Boxes never overlap, so at most one lane contributes a non-zero colour.
  always_comb begin
    w_any = |w_in_box;
    w_mix = '0;
    for (int i = 0; i < N_LANES; i++) w_mix = w_mix | w_rgb[i];
  end

  // Output register gives the one-clock pixel latency.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      active <= 1'b0;
      red    <= '0;
      green  <= '0;
      blue   <= '0;
    end else begin
      active <= w_any;
      red    <= w_mix[11:8];
      green  <= w_mix[7:4];
      blue   <= w_mix[3:0];
    end
  end

endmodule

// File: tb/tb_fret_bank.sv
// Scoreboard bench for fret_bank: probes push expected pixels, monitor checks them.
module tb_fret_bank;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        frame_tick = 1'b0;
  logic        write = 1'b0;
  logic [31:0] data_in = '0;
  logic        active;
  logic [3:0]  red, green, blue;

  int errors = 0;
  int checks = 0;

  logic [12:0] exp_q[$];
  string       name_q[$];
  logic        probe = 1'b0;
  logic        probe_d = 1'b0;

  // expected pixels {active, r, g, b}
  localparam logic [12:0] PX_OFF   = 13'h0000;
  localparam logic [12:0] PX_WHITE = {1'b1, 12'hFFF};
  localparam logic [12:0] PX_MISS  = {1'b1, 12'h800};
  localparam logic [12:0] PX_G     = {1'b1, 12'h0F0};
  localparam logic [12:0] PX_G_D   = {1'b1, 12'h070};
  localparam logic [12:0] PX_R_D   = {1'b1, 12'h700};
  localparam logic [12:0] PX_Y     = {1'b1, 12'hFF0};
  localparam logic [12:0] PX_B_D   = {1'b1, 12'h007};
  localparam logic [12:0] PX_O     = {1'b1, 12'hF80};

  // lane left edges and a y inside the row
  localparam int X0 = 160, X1 = 224, X2 = 288, X3 = 352, X4 = 416, YIN = 402;

  fret_bank dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .frame_tick(frame_tick), .write(write), .data_in(data_in),
    .active(active), .red(red), .green(green), .blue(blue)
  );

  always #5 Clk = ~Clk;

  function automatic void compare(input string nm, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endfunction

  // Monitor: a probe's pixel appears one clock after it was driven.
  always @(posedge Clk) probe_d <= probe;
  always @(negedge Clk) begin
    if (probe_d) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL monitor: output with empty scoreboard");
      end else begin
        compare(name_q.pop_front(), {active, red, green, blue}, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wr(input logic [31:0] d, input logic tk);
    write = 1'b1; data_in = d; frame_tick = tk;
    @(negedge Clk);
    write = 1'b0; data_in = '0; frame_tick = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  task automatic px(input int x, input int y, input logic [12:0] exp, input string nm);
    DrawX = 10'(x); DrawY = 10'(y); probe = 1'b1;
    exp_q.push_back(exp); name_q.push_back(nm);
    @(negedge Clk);
    probe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    #1 compare("reset_out", {active, red, green, blue}, PX_OFF);
    cyc(2);
    Reset_n = 1'b1;
    cyc(2);
    px(0, 0, PX_OFF, "outside_origin");
    px(X0 + 5, YIN, PX_G_D, "idle_lane0");

    // 1: reset in the middle of a HIT flash
    wr(32'h4000_0002, 1'b0);
    cyc(1);
    px(X1 + 3, YIN, PX_WHITE, "hit_before_reset");
    DrawX = 10'(X1 + 3); DrawY = 10'(YIN);
    @(posedge Clk); #2;
    Reset_n = 1'b0;
    #1 compare("reset_async_out", {active, red, green, blue}, PX_OFF);
    cyc(2);
    Reset_n = 1'b1;
    cyc(2);
    px(X1 + 3, YIN, PX_R_D, "idle_after_reset");

    // 2: press lanes 0,2,4
    wr(32'h0000_0015, 1'b0);
    cyc(2);
    px(X0 + 5, 400 + 2, PX_G, "press_lane0");
    px(X1 + 5, YIN, PX_R_D, "dim_lane1");
    px(X2 + 5, YIN, PX_Y, "press_lane2");
    px(X3 + 5, YIN, PX_B_D, "dim_lane3");
    px(X4 + 5, YIN, PX_O, "press_lane4");

    // 3: HIT lane1 lasts exactly eight frames, then back to dim idle
    wr(32'h4000_0002, 1'b0);
    cyc(1);
    px(X1 + 10, YIN, PX_WHITE, "hit_lane1_start");
    for (int k = 1; k <= 8; k++) begin
      tick();
      px(X1 + 10, YIN, (k < 8) ? PX_WHITE : PX_R_D, $sformatf("hit_lane1_f%0d", k));
    end

    // 4: MISS overrides HIT mid-flash; ends in pressed (lane2 is in the mask)
    wr(32'h4000_0004, 1'b0);
    for (int k = 1; k <= 3; k++) tick();
    px(X2 + 1, YIN, PX_WHITE, "hit_lane2_f3");
    wr(32'h8000_0004, 1'b0);
    px(X2 + 1, YIN, PX_MISS, "miss_lane2_start");
    for (int k = 1; k <= 4; k++) begin
      tick();
      px(X2 + 1, YIN, (k < 4) ? PX_MISS : PX_Y, $sformatf("miss_lane2_f%0d", k));
    end

    // 5: HIT lane0 coincident with frame_tick loads without decrement;
    //    lane4 (MISS in flight) decrements on that same tick
    wr(32'h8000_0010, 1'b0);
    cyc(1);
    wr(32'h4000_0001, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      px(X0 + 20, YIN, (k < 8) ? PX_WHITE : PX_G, $sformatf("coinc_lane0_f%0d", k));
      px(X4 + 20, YIN, (k < 3) ? PX_MISS : PX_O, $sformatf("coinc_lane4_f%0d", k));
    end

    // 6: box edges on lane3, then CLEAR beats a concurrent tick
    px(X3 - 1,  YIN, PX_OFF, "edge_x_left_out");
    px(X3,      YIN, PX_B_D, "edge_x_left_in");
    px(X3 + 47, YIN, PX_B_D, "edge_x_right_in");
    px(X3 + 48, YIN, PX_OFF, "edge_x_right_out");
    px(X3 + 5,  399, PX_OFF, "edge_y_top_out");
    px(X3 + 5,  415, PX_B_D, "edge_y_bot_in");
    px(X3 + 5,  416, PX_OFF, "edge_y_bot_out");
    wr(32'h4000_0008, 1'b0);
    px(X3 + 5, YIN, PX_WHITE, "hit_lane3_pre_clear");
    wr(32'hC000_0000, 1'b1);
    px(X0 + 5, YIN, PX_G_D, "clear_lane0");
    px(X2 + 5, YIN, PX_Y - 13'h0880, "clear_lane2");
    px(X3 + 5, YIN, PX_B_D, "clear_lane3");
    px(X4 + 5, YIN, PX_O - 13'h0840, "clear_lane4");
    cyc(5);
    px(X0 + 5, YIN, PX_G_D, "clear_lane0_stays");

    cyc(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
